// File: rtl/demux_32_1_2.sv
// demux_32_1_2 -- registered 1-to-2 demultiplexer for WIDTH-bit words.
//
// The select s steers each input word to one of two outputs. Output c0 feeds
// the register-write port and c1 feeds the store/forward port. Each output has
// a one-entry holding register with its own valid/ready handshake, so either
// destination can stall without blocking the other. A full port that is
// drained and loaded on the same edge stays full, which gives one word per
// clock per port.
//
// Optional build macro DEMUX_CNT_EN adds the cnt0/cnt1 ports. Each is a
// CNT_W-bit counter that counts words delivered on its port and wraps around
// at 2^CNT_W. Without the macro, the counters and their ports do not exist.
//
// Reset is synchronous and active-low. A reset discards held words and clears
// both data registers to zero.

module demux_32_1_2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             s,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [WIDTH-1:0] c0,
  output logic             c0_valid,
  input  logic             c0_ready,
  output logic [WIDTH-1:0] c1,
  output logic             c1_valid,
  input  logic             c1_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_e;

  port_state_e      state_q [2];
  port_state_e      state_d [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];

  logic [1:0] out_ready;
  logic [1:0] slot_free;
  logic [1:0] drain;
  logic [1:0] load;

  assign out_ready = {c1_ready, c0_ready};

  // Per-port events and the input handshake. a_ready looks only at the port that s selects.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    slot_free = '0;
    drain     = '0;
    load      = '0;
    for (int k = 0; k < 2; k++) begin
      slot_free[k] = (state_q[k] == EMPTY) | out_ready[k];
      drain[k]     = (state_q[k] == FULL) & out_ready[k];
    end
    a_ready = slot_free[s];
    for (int k = 0; k < 2; k++) begin
      load[k] = a_valid & slot_free[s] & (s == 1'(k));
    end
  end

  // Next state of each holding register. A load wins over a drain, so a full
  // port that is drained and loaded on the same edge stays full.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      if (load[k]) begin
        state_d[k] = FULL;
        data_d[k]  = a;
      end else if (drain[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  // Port state and data registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of block order.
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= EMPTY;
        // NOTE: the data registers are reset as well as the valids, because c0/c1 must read 0 after reset and not stale words.
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign c0       = data_q[0];
  assign c1       = data_q[1];
  assign c0_valid = (state_q[0] == FULL);
  assign c1_valid = (state_q[1] == FULL);

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  // Delivered-word counters. They count one per drain and wrap naturally at 2^CNT_W.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(drain[k]);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`else
  // Counter build is off, so cnt0/cnt1 and their logic are absent.
`endif

endmodule

// File: tb/tb_demux_32_1_2.sv
// tb_demux_32_1_2 -- self-checking bench for demux_32_1_2.
//
// Each output port is modelled as a queue that holds at most one word. The
// queue head is the expected output word. Once a port drains, the expected
// word is the last value delivered on that port. Directed scenarios use
// literal expectations, then a randomized phase follows. Counters are
// checked when DEMUX_CNT_EN is defined; the bench builds the DUT with CNT_W=4
// so that counter wrap is quick to reach.

module tb_demux_32_1_2;

  localparam int TB_CNT_W = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic        s;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] c0;
  logic        c0_valid;
  logic        c0_ready;
  logic [31:0] c1;
  logic        c1_valid;
  logic        c1_ready;
`ifdef DEMUX_CNT_EN
  logic [TB_CNT_W-1:0] cnt0;
  logic [TB_CNT_W-1:0] cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  demux_32_1_2 #(.WIDTH(32), .CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .s        (s),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .c0       (c0),
    .c0_valid (c0_valid),
    .c0_ready (c0_ready),
    .c1       (c1),
    .c1_valid (c1_valid),
    .c1_ready (c1_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: per-port queues. The model advances on each rising edge
  // from the inputs seen just before that edge.
  // ---------------------------------------------------------------------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  int          mcnt0 = 0;
  int          mcnt1 = 0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    bit take;
    bit d0, d1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      mcnt0 = 0;
      mcnt1 = 0;
      armed = 1'b1;
    end else if (armed) begin
      // The target port can take a word if it is empty now or is being drained.
      take = a_valid && (s ? (q1.size() == 0 || c1_ready) : (q0.size() == 0 || c0_ready));
      d0 = (q0.size() != 0) && c0_ready;
      d1 = (q1.size() != 0) && c1_ready;
      if (d0) begin
        last0 = q0.pop_front();
        mcnt0 = (mcnt0 + 1) % (1 << TB_CNT_W);
      end
      if (d1) begin
        last1 = q1.pop_front();
        mcnt1 = (mcnt1 + 1) % (1 << TB_CNT_W);
      end
      if (take && !s) begin
        q0.push_back(a);
        last0 = a;
      end
      if (take && s) begin
        q1.push_back(a);
        last1 = a;
      end
    end
  end

  // Compare process: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("c0_valid", c0_valid, q0.size() != 0);
      check("c1_valid", c1_valid, q1.size() != 0);
      check("c0_data", c0, (q0.size() != 0) ? q0[0] : last0);
      check("c1_data", c1, (q1.size() != 0) ? q1[0] : last1);
      check("a_ready", a_ready, s ? (q1.size() == 0 || c1_ready) : (q0.size() == 0 || c0_ready));
`ifdef DEMUX_CNT_EN
      check("cnt0", cnt0, mcnt0);
      check("cnt1", cnt1, mcnt1);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations that pin the model.
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    a        = '0;
    s        = 1'b0;
    a_valid  = 1'b0;
    c0_ready = 1'b0;
    c1_ready = 1'b0;

    // Reset / idle
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_c0_valid", c0_valid, 0);
    check("rst_c1_valid", c1_valid, 0);
    check("rst_c0", c0, 0);
    check("rst_c1", c1, 0);
    check("rst_a_ready", a_ready, 1);

    // Single route to c1 with a stall
    step();
    a = 32'hDEADBEEF; s = 1'b1; a_valid = 1'b1; c1_ready = 1'b0;
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("route_c1", c1, 32'hDEADBEEF);
    check("route_c1_valid", c1_valid, 1);
    check("route_c0_valid", c0_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("stall_c1", c1, 32'hDEADBEEF);
      check("stall_c1_valid", c1_valid, 1);
    end
    step();
    c1_ready = 1'b1;
    step();
    c1_ready = 1'b0;
    @(negedge clk);
    check("drain_c1_valid", c1_valid, 0);

    // Backpressure isolation
    step();
    a = 32'h1; s = 1'b0; a_valid = 1'b1; c0_ready = 1'b0;
    step();
    a = 32'h3; s = 1'b0;
    @(negedge clk);
    check("bp_c0_valid", c0_valid, 1);
    check("bp_a_ready_s0", a_ready, 0);
    #1;
    a = 32'h2; s = 1'b1;
    #1;
    check("bp_a_ready_s1", a_ready, 1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("bp_c1", c1, 32'h2);
    check("bp_c1_valid", c1_valid, 1);
    check("bp_c0_held", c0, 32'h1);
    step();
    c0_ready = 1'b1; c1_ready = 1'b1;
    step();
    c0_ready = 1'b0; c1_ready = 1'b0;

    // Streaming on port 0
    step();
    c0_ready = 1'b1; s = 1'b0; a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(32'h10 + i);
      @(negedge clk);
      check("stream_a_ready", a_ready, 1);
      if (i > 0) begin
        check("stream_c0", c0, 32'(32'h10 + i - 1));
        check("stream_c0_valid", c0_valid, 1);
      end
      step();
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("stream_c0_last", c0, 32'h13);
    step();
    c0_ready = 1'b0;

    // Mid-operation reset with both ports full
    step();
    a = 32'hAAAA5555; s = 1'b0; a_valid = 1'b1;
    step();
    a = 32'h5555AAAA; s = 1'b1;
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("mid_c0_full", c0_valid, 1);
    check("mid_c1_full", c1_valid, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_c0_valid", c0_valid, 0);
    check("mid_rst_c1_valid", c1_valid, 0);
    check("mid_rst_c0", c0, 0);

`ifdef DEMUX_CNT_EN
    // Counters: 3 drains on port 0 and 1 drain on port 1, then wrap port 0 at 16
    step();
    c0_ready = 1'b1; c1_ready = 1'b1; a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(100 + i);
      s = (i == 3);
      step();
    end
    a_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    check("cnt0_three", cnt0, 3);
    check("cnt1_one", cnt1, 1);
    step();
    a_valid = 1'b1; s = 1'b0;
    for (int i = 0; i < 14; i++) begin
      a = 32'(200 + i);
      step();
    end
    a_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    check("cnt0_wrap", cnt0, 1);
    check("cnt1_hold", cnt1, 1);
    step();
    c0_ready = 1'b0; c1_ready = 1'b0;
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n    = ($urandom_range(0, 199) != 0);
      a        = $urandom;
      s        = 1'($urandom_range(0, 1));
      a_valid  = ($urandom_range(0, 9) < 7);
      c0_ready = ($urandom_range(0, 9) < 6);
      c1_ready = ($urandom_range(0, 9) < 4);
    end
    step();
    rst_n = 1'b1; a_valid = 1'b0; c0_ready = 1'b1; c1_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("end_c0_empty", c0_valid, 0);
    check("end_c1_empty", c1_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_32_1_2.md
Name: demux_32_1_2

Overview:
- Registered 1-to-2 demultiplexer for 32-bit words; the inverse of the 2:1 word mux.
- Steers one input word stream to one of two destinations (c0 or c1), chosen per word by select s.
- Sits after the ALU result path, routing results to the register-write port (c0) or the store/forward port (c1).
- Each output has a one-entry holding register with a valid/ready handshake, so either destination can stall independently.

Parameters:
- WIDTH, 32, data width of the input word and both output words.
- CNT_W, 16, width of the per-port transfer counters (used only when the optional feature is compiled in).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a  input  WIDTH  input data word.
- s  input  1  destination select: 0 routes to c0, 1 routes to c1.
- a_valid  input  1  a and s are valid this cycle.
- a_ready  output  1  block can accept the input word this cycle.
- c0  output  WIDTH  port-0 data.
- c0_valid  output  1  c0 holds a word.
- c0_ready  input  1  port-0 consumer accepts this cycle.
- c1  output  WIDTH  port-1 data.
- c1_valid  output  1  c1 holds a word.
- c1_ready  input  1  port-1 consumer accepts this cycle.
- cnt0  output  CNT_W  words delivered on port 0 (only with DEMUX_CNT_EN).
- cnt1  output  CNT_W  words delivered on port 1 (only with DEMUX_CNT_EN).

Behaviour:
- Reset, while rst_n=0 at a clock edge:
  - c0, c1 = 0.
  - c0_valid, c1_valid = 0.
  - cnt0, cnt1 = 0.
  - a_ready is driven from the reset-state registers, so it is 1 in the cycle after reset.
- Port state machine, one per port k (0 and 1):
  - EMPTY (ck_valid=0) and FULL (ck_valid=1).
  - ck_valid and ck are registered outputs only; there is no combinational path from a to ck.
- Events per port:
  - drain_k = ck_valid & ck_ready.
  - load_k = a_valid & a_ready & (s==k).
- a_ready is combinational:
  - a_ready = (s==0) ? (~c0_valid | c0_ready) : (~c1_valid | c1_ready).
  - a_ready depends on s and on the target port only; the non-selected port's state never blocks.
- Transitions:
  - EMPTY & load_k -> FULL; ck <= a.
  - FULL & drain_k & ~load_k -> EMPTY; ck holds its last value.
  - FULL & drain_k & load_k -> stays FULL; ck <= a. This is back-to-back operation: full throughput of one word per clock per port.
  - FULL & ~drain_k -> stays FULL; ck is held stable (ck must not change while ck_valid=1 and ck_ready=0).
  - EMPTY & ~load_k -> stays EMPTY.
- Latency: a word accepted at edge N is presented at ck with ck_valid=1 from edge N through at least the next cycle.
- Ordering: words to the same port are delivered in acceptance order. No ordering is guaranteed between ports.
- Input rules:
  - a_valid=0: a and s are ignored and no state changes.
  - The upstream may change a or s while a_valid=1 and a_ready=0. Re-evaluation of a_ready on the new s is allowed; no word is lost or duplicated.
- Simultaneous events: draining port 0 while loading port 1 in the same cycle is legal and independent.
- Reset mid-operation: held words are discarded, with no drain handshake required; the outputs go EMPTY on the reset edge.
- Data width: the data path is a straight copy. There is no arithmetic, and WIDTH bits are passed unchanged.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Ports cnt0 and cnt1 exist.
  - cntk increments by 1 on every drain_k edge.
  - It wraps modulo 2^CNT_W (0xFFFF + 1 -> 0x0000 with the default width).
  - It resets to 0 on rst_n=0.
- Not defined:
  - Ports cnt0 and cnt1 and the counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 edges, then release. Check c0_valid=c1_valid=0, c0=c1=0 and a_ready=1 with a_valid=0.
- Single route:
  - Drive a=0xDEADBEEF, s=1, a_valid=1 for one cycle, with c1_ready=0.
  - Next cycle: c1=0xDEADBEEF, c1_valid=1, c0_valid=0.
  - c1 stays stable for 5 stall cycles, then drains when c1_ready=1.
- Backpressure isolation:
  - Fill c0 with 0x00000001 while c0_ready=0.
  - A new word with s=0 sees a_ready=0.
  - A word 0x00000002 with s=1 is accepted the same cycle and appears on c1.
- Streaming:
  - c0_ready=1 constantly; send 0x10, 0x11, 0x12, 0x13 with s=0 on consecutive cycles.
  - a_ready stays 1 throughout.
  - c0 shows 0x10..0x13 on consecutive cycles, in order.
- Mid-operation reset: both ports FULL (0xAAAA5555 on c0, 0x5555AAAA on c1) with readies low. Assert rst_n=0 for one edge; both valids drop to 0 on that edge.
- Counter (DEMUX_CNT_EN): 3 drains on port 0 and 1 on port 1 give cnt0=3, cnt1=1.
- Counter wrap (DEMUX_CNT_EN): with CNT_W=4, 17 drains on port 0 give cnt0=1.
